// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared encodings and helpers for the MIPS pipeline stages
//
// Purpose: select encodings used by the MEM/WB write-back stage and the
// byte-offset width helper shared by the stage and its load extractor.
// Ports: none (package).

package mips_pipe_pkg;

  // Destination register select.
  typedef enum logic [1:0] {
    REG_DST_RT   = 2'd0,
    REG_DST_RD   = 2'd1,
    REG_DST_LINK = 2'd2,
    REG_DST_NONE = 2'd3
  } reg_dst_e;

  // Write-back data select; encoding 3 aliases the ALU result.
  typedef enum logic [1:0] {
    M2R_ALU  = 2'd0,
    M2R_MEM  = 2'd1,
    M2R_LINK = 2'd2
  } m2r_e;

  // Load extraction modes; encodings 5..7 behave as a full word.
  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } ld_ext_e;

  // Width of a byte offset inside a DATA_W-bit word.
  function automatic int boff_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/load_ext.sv
// rtl/load_ext.sv - load-data sub-word extraction with sign/zero extension
//
// Purpose: pick a byte or halfword out of the raw memory word (little-endian)
// and extend it to DATA_W; word and reserved modes pass the word unchanged.
// Ports:
//   word      in  DATA_W  raw memory word
//   ld_ext    in  3       load mode (ld_ext_e)
//   byte_off  in  BOFF_W  byte offset within the word
//   ext       out DATA_W  extended load value

module load_ext
  import mips_pipe_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int BOFF_W = boff_w(DATA_W)
) (
  input  logic [DATA_W-1:0] word,
  input  logic [2:0]        ld_ext,
  input  logic [BOFF_W-1:0] byte_off,
  output logic [DATA_W-1:0] ext
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    // Shift the addressed lane down to bit 0; the halfword lane ignores
    // byte_off[0], so misaligned halfwords read the enclosing aligned half.
    byte_v = 8'(word >> {byte_off, 3'b000});
    half_v = 16'(word >> {byte_off[BOFF_W-1:1], 4'b0000});

    ext = word;
    case (ld_ext_e'(ld_ext))
      LD_B:    ext = {{(DATA_W-8){byte_v[7]}}, byte_v};
      LD_BU:   ext = {{(DATA_W-8){1'b0}}, byte_v};
      LD_H:    ext = {{(DATA_W-16){half_v[15]}}, half_v};
      LD_HU:   ext = {{(DATA_W-16){1'b0}}, half_v};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/mem_wb_sel.sv
// rtl/mem_wb_sel.sv - MEM/WB pipeline stage with final write-back selection
//
// Purpose: registers the write-back destination, enable and data for the
// register file (and forwarding network), with stall, flush, link-register
// destination, load extraction and $0 write suppression. Latency is 1 cycle.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   stall, flush      hold stage / insert bubble (flush wins)
//   in_valid          MEM-stage instruction valid
//   in_reg_write      instruction writes the register file
//   in_rt, in_rd      candidate destination fields
//   in_reg_dst        0 rt, 1 rd, 2 LINK_REG, 3 none
//   in_mem_to_reg     0 ALU, 1 memory, 2 pc + LINK_OFF, 3 ALU
//   in_alu_ans        ALU result
//   in_mem_dout       raw memory word
//   in_pc             instruction PC
//   in_ld_ext         load mode
//   in_byte_off       byte offset within the word
//   wb_valid, wb_we   registered valid and write enable
//   wb_addr, wb_data  registered destination and data
//   wb_pc             registered PC for trace

module mem_wb_sel
  import mips_pipe_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int REG_AW   = 5,
  parameter  int LINK_REG = 31,
  parameter  int LINK_OFF = 8,
  localparam int BOFF_W   = boff_w(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_reg_write,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [1:0]        in_reg_dst,
  input  logic [1:0]        in_mem_to_reg,
  input  logic [DATA_W-1:0] in_alu_ans,
  input  logic [DATA_W-1:0] in_mem_dout,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [2:0]        in_ld_ext,
  input  logic [BOFF_W-1:0] in_byte_off,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] wb_pc
);

  localparam logic [REG_AW-1:0] LINK_ADDR = REG_AW'(LINK_REG);
  localparam logic [DATA_W-1:0] LINK_INC  = DATA_W'(LINK_OFF);

  logic [DATA_W-1:0] ld_val;
  logic [REG_AW-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_we;

  logic              valid_d, valid_q;
  logic              we_d,    we_q;
  logic [REG_AW-1:0] addr_d,  addr_q;
  logic [DATA_W-1:0] data_d,  data_q;
  logic [DATA_W-1:0] pc_d,    pc_q;

  load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .word     (in_mem_dout),
    .ld_ext   (in_ld_ext),
    .byte_off (in_byte_off),
    .ext      (ld_val)
  );

  // Destination, data and enable selection for the instruction in MEM.
  always_comb begin
    sel_addr = '0;
    case (reg_dst_e'(in_reg_dst))
      REG_DST_RT:   sel_addr = in_rt;
      REG_DST_RD:   sel_addr = in_rd;
      REG_DST_LINK: sel_addr = LINK_ADDR;
      default:      sel_addr = '0;
    endcase

    sel_data = in_alu_ans;
    case (m2r_e'(in_mem_to_reg))
      M2R_MEM:  sel_data = ld_val;
      M2R_LINK: sel_data = in_pc + LINK_INC;   // wraps modulo 2^DATA_W
      default:  sel_data = in_alu_ans;
    endcase

    // $0 is hard-wired zero, so a write to it never reaches the file.
    sel_we = in_valid & in_reg_write & (sel_addr != '0);
  end

  // Stage register next-state: flush beats stall; reset is in the flop block.
  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
      addr_d  = '0;
      data_d  = '0;
      pc_d    = '0;
    end else if (!stall) begin
      // Address, data and pc load even for an invalid slot.
      valid_d = in_valid;
      we_d    = sel_we;
      addr_d  = sel_addr;
      data_d  = sel_data;
      pc_d    = in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign wb_valid = valid_q;
  assign wb_we    = we_q;
  assign wb_addr  = addr_q;
  assign wb_data  = data_q;
  assign wb_pc    = pc_q;

endmodule

// File: tb/tb_mem_wb_sel.sv
// tb/tb_mem_wb_sel.sv - self-checking bench for mem_wb_sel at DATA_W 32 and 64

module tb_mem_wb_sel;

  logic        clk = 1'b0;
  logic        reset, stall, flush, valid, reg_write;
  logic [4:0]  rt, rd;
  logic [1:0]  reg_dst, m2r;
  logic [63:0] alu, mem, pc;
  logic [2:0]  ld_ext;
  logic [2:0]  off;

  logic        v32, we32, v64, we64;
  logic [4:0]  addr32, addr64;
  logic [31:0] data32, pc32;
  logic [63:0] data64, pc64;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  mem_wb_sel #(.DATA_W(32)) dut32 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(valid), .in_reg_write(reg_write), .in_rt(rt), .in_rd(rd),
    .in_reg_dst(reg_dst), .in_mem_to_reg(m2r),
    .in_alu_ans(alu[31:0]), .in_mem_dout(mem[31:0]), .in_pc(pc[31:0]),
    .in_ld_ext(ld_ext), .in_byte_off(off[1:0]),
    .wb_valid(v32), .wb_we(we32), .wb_addr(addr32), .wb_data(data32), .wb_pc(pc32)
  );

  mem_wb_sel #(.DATA_W(64)) dut64 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(valid), .in_reg_write(reg_write), .in_rt(rt), .in_rd(rd),
    .in_reg_dst(reg_dst), .in_mem_to_reg(m2r),
    .in_alu_ans(alu), .in_mem_dout(mem), .in_pc(pc),
    .in_ld_ext(ld_ext), .in_byte_off(off),
    .wb_valid(v64), .wb_we(we64), .wb_addr(addr64), .wb_data(data64), .wb_pc(pc64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference load extraction using integer lane arithmetic.
  function automatic logic [63:0] ld_model(input logic [63:0] w, input int mode,
                                           input int boff, input logic [63:0] mask);
    longint unsigned lane;
    longint signed   val;
    case (mode)
      1, 2: begin
        lane = (w / (64'd1 << (8 * boff))) % 256;
        val  = (mode == 1 && lane >= 128) ? longint'(lane) - 256 : longint'(lane);
        return 64'(val) & mask;
      end
      3, 4: begin
        lane = (w / (64'd1 << (16 * (boff / 2)))) % 65536;
        val  = (mode == 3 && lane >= 32768) ? longint'(lane) - 65536 : longint'(lane);
        return 64'(val) & mask;
      end
      default: return w & mask;
    endcase
  endfunction

  // Expected stage contents, index 0 = 32-bit instance, 1 = 64-bit instance.
  logic        m_v[2], m_we[2];
  logic [4:0]  m_addr[2];
  logic [63:0] m_data[2], m_pc[2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [63:0] mask;
      logic [4:0]  dest;
      logic [63:0] d;
      mask = (k == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      dest = (reg_dst == 0) ? rt : (reg_dst == 1) ? rd : (reg_dst == 2) ? 5'd31 : 5'd0;
      if (m2r == 1)      d = ld_model(mem, int'(ld_ext), (k == 1) ? int'(off) : int'(off % 4), mask);
      else if (m2r == 2) d = (pc + 64'd8) & mask;
      else               d = alu & mask;
      if (reset || flush) begin
        m_v[k] <= 1'b0; m_we[k] <= 1'b0; m_addr[k] <= '0; m_data[k] <= '0; m_pc[k] <= '0;
      end else if (!stall) begin
        m_v[k]    <= valid;
        m_we[k]   <= valid && reg_write && (dest != 0);
        m_addr[k] <= dest;
        m_data[k] <= d;
        m_pc[k]   <= pc & mask;
      end
    end
    started <= 1'b1;
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("valid32", {63'b0, v32}, {63'b0, m_v[0]});
      chk("we32",    {63'b0, we32}, {63'b0, m_we[0]});
      chk("addr32",  {59'b0, addr32}, {59'b0, m_addr[0]});
      chk("data32",  {32'b0, data32}, m_data[0]);
      chk("pc32",    {32'b0, pc32}, m_pc[0]);
      chk("valid64", {63'b0, v64}, {63'b0, m_v[1]});
      chk("we64",    {63'b0, we64}, {63'b0, m_we[1]});
      chk("addr64",  {59'b0, addr64}, {59'b0, m_addr[1]});
      chk("data64",  data64, m_data[1]);
      chk("pc64",    pc64, m_pc[1]);
    end
  end

  task automatic set_idle();
    reset = 0; stall = 0; flush = 0; valid = 1; reg_write = 1;
    rt = 5'd0; rd = 5'd0; reg_dst = 2'd1; m2r = 2'd0;
    alu = '0; mem = '0; pc = '0; ld_ext = 3'd0; off = 3'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_chk(input string name, input logic [2:0] mode, input logic [2:0] o,
                          input logic [31:0] exp);
    @(negedge clk);
    m2r = 2'd1; ld_ext = mode; off = o; rd = 5'd9; reg_dst = 2'd1;
    step();
    chk(name, {32'b0, data32}, {32'b0, exp});
  endtask

  initial begin
    set_idle();
    reset = 1;

    // 1: reset while loading a valid instruction, then a plain load.
    @(negedge clk);
    reset = 1; rd = 5'd5; reg_dst = 2'd1; alu = 64'h1234;
    step();
    chk("rst_valid", {63'b0, v32}, 64'd0);
    chk("rst_we",    {63'b0, we32}, 64'd0);
    chk("rst_addr",  {59'b0, addr32}, 64'd0);
    chk("rst_data",  {32'b0, data32}, 64'd0);
    chk("rst_pc",    {32'b0, pc32}, 64'd0);
    @(negedge clk);
    reset = 0;
    step();
    chk("ld_addr", {59'b0, addr32}, 64'd5);
    chk("ld_data", {32'b0, data32}, 64'h1234);
    chk("ld_we",   {63'b0, we32}, 64'd1);

    // 2: byte and halfword extraction.
    @(negedge clk);
    mem = 64'h80FF7F01;
    load_chk("lb0",  3'd1, 3'd0, 32'h00000001);
    load_chk("lb1",  3'd1, 3'd1, 32'h0000007F);
    load_chk("lb2",  3'd1, 3'd2, 32'hFFFFFFFF);
    load_chk("lb3",  3'd1, 3'd3, 32'hFFFFFF80);
    load_chk("lbu3", 3'd2, 3'd3, 32'h00000080);
    load_chk("lh2",  3'd3, 3'd2, 32'hFFFF80FF);
    load_chk("lhu3", 3'd4, 3'd3, 32'h000080FF);

    // 3: link write and wrap.
    @(negedge clk);
    reg_dst = 2'd2; m2r = 2'd2; pc = 64'h3000;
    step();
    chk("link_addr", {59'b0, addr32}, 64'd31);
    chk("link_data", {32'b0, data32}, 64'h3008);
    chk("link_we",   {63'b0, we32}, 64'd1);
    @(negedge clk);
    pc = 64'hFFFFFFFC;
    step();
    chk("link_wrap32", {32'b0, data32}, 64'h4);

    // 4: destination $0 suppresses the write.
    @(negedge clk);
    reg_dst = 2'd0; rt = 5'd0; m2r = 2'd0; alu = 64'h55;
    step();
    chk("r0_valid", {63'b0, v32}, 64'd1);
    chk("r0_addr",  {59'b0, addr32}, 64'd0);
    chk("r0_we",    {63'b0, we32}, 64'd0);

    // 5: stall holds for three cycles; stall with flush clears.
    @(negedge clk);
    reg_dst = 2'd1; rd = 5'd7; alu = 64'hCAFE0001;
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stall = 1; rd = 5'($urandom); alu = {$urandom, $urandom}; pc = {$urandom, $urandom};
      step();
      chk("stall_data", {32'b0, data32}, 64'hCAFE0001);
      chk("stall_addr", {59'b0, addr32}, 64'd7);
      chk("stall_we",   {63'b0, we32}, 64'd1);
    end
    @(negedge clk);
    stall = 1; flush = 1;
    step();
    chk("sf_valid", {63'b0, v32}, 64'd0);
    chk("sf_we",    {63'b0, we32}, 64'd0);
    chk("sf_data",  {32'b0, data32}, 64'd0);

    // 6: 64-bit instance, top byte and full-width link wrap.
    @(negedge clk);
    stall = 0; flush = 0;
    mem = 64'h8000_0000_0000_0000; m2r = 2'd1; ld_ext = 3'd1; off = 3'd7;
    step();
    chk("lb7_64", data64, 64'hFFFF_FFFF_FFFF_FF80);
    @(negedge clk);
    m2r = 2'd2; reg_dst = 2'd2; pc = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    chk("wrap64", data64, 64'h7);
    chk("wrap32", {32'b0, data32}, 64'h7);

    // Randomized traffic checked by the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset     = ($urandom % 50) == 0;
      stall     = ($urandom % 6) == 0;
      flush     = ($urandom % 10) == 0;
      valid     = ($urandom % 5) != 0;
      reg_write = ($urandom % 4) != 0;
      rt        = (($urandom % 8) == 0) ? 5'd0 : 5'($urandom);
      rd        = (($urandom % 8) == 0) ? 5'd0 : 5'($urandom);
      reg_dst   = 2'($urandom);
      m2r       = 2'($urandom);
      ld_ext    = 3'($urandom);
      off       = 3'($urandom);
      alu       = {$urandom, $urandom};
      mem       = {$urandom, $urandom};
      pc        = (($urandom % 16) == 0) ? 64'hFFFF_FFFF_FFFF_FFF9 - 64'($urandom % 8)
                                         : {$urandom, $urandom};
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
